// File: rtl/jamma_input_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : jamma_input_ctrl_if
//  Description : Signal bundle between the JAMMA edge connector / on-board
//                controls and the player-input front end.
//                All signals are active-low (0 = pressed).
//  Ports       : JJOY[7:0]     shared player bus (P1 or P2, chosen by JSELECT)
//                JOYSTICK[5:0] on-board joystick, same bit order as JJOY[5:0]
//                JCOIN[1:0]    raw coin switches {P2,P1}
//                JSELECT       bus select, 0 = P1, 1 = P2
//                JOY1[7:0]     cleaned player 1 inputs
//                JOY2[7:0]     cleaned player 2 inputs
//                COIN[1:0]     stretched coin pulses {P2,P1}
//  Modports    : master - the input controller (drives JSELECT and results)
//                slave  - the board/harness side (drives the raw switches)
//  Revision    : 1.0 - initial release
// ============================================================================
interface jamma_input_ctrl_if;
  logic [7:0] JJOY;
  logic [5:0] JOYSTICK;
  logic [1:0] JCOIN;
  logic       JSELECT;
  logic [7:0] JOY1;
  logic [7:0] JOY2;
  logic [1:0] COIN;

  modport master (
    input  JJOY, JOYSTICK, JCOIN,
    output JSELECT, JOY1, JOY2, COIN
  );

  modport slave (
    output JJOY, JOYSTICK, JCOIN,
    input  JSELECT, JOY1, JOY2, COIN
  );
endinterface
`default_nettype wire

// File: rtl/jamma_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : jamma_input_ctrl
//  Description : JAMMA player-input front end. Time-multiplexes the shared
//                JJOY bus between players via JSELECT, waits a settle window,
//                samples and debounces each player, merges the on-board
//                joystick into player 1, and debounces/stretches coins.
//                Everything is active-low (0 = pressed).
//  Ports       : CLK      pixel clock, the only clock
//                RESET_N  asynchronous active-low reset
//                bus      jamma_input_ctrl_if.master
//                         (JJOY, JOYSTICK, JCOIN in; JSELECT, JOY1, JOY2,
//                          COIN out)
//  Parameters  : SETTLE    clocks after a JSELECT change before sampling (>=3)
//                DEB_COUNT consecutive differing samples to flip a bit (1..15)
//                COIN_MIN  width in clocks of each COIN low pulse
//  Macros      : JAMMA_SOCD_EN - when defined, opposing directions held
//                together (up+down, left+right) are both released at the
//                outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module jamma_input_ctrl #(
  parameter int SETTLE    = 4,
  parameter int DEB_COUNT = 3,
  parameter int COIN_MIN  = 8192
) (
  input  logic               CLK,
  input  logic               RESET_N,
  jamma_input_ctrl_if.master bus
);

  localparam int c_SW = $clog2(SETTLE + 1);
  localparam int c_DW = $clog2(DEB_COUNT + 1);
  localparam int c_CW = $clog2(COIN_MIN + 1);

  localparam logic [c_SW-1:0] c_SET_LAST  = c_SW'(SETTLE - 1);
  localparam logic [c_DW-1:0] c_DEB_LAST  = c_DW'(DEB_COUNT - 1);
  localparam logic [c_CW-1:0] c_COIN_LAST = c_CW'(COIN_MIN - 1);

  localparam logic [1:0] c_P1_SET = 2'd0;
  localparam logic [1:0] c_P1_SMP = 2'd1;
  localparam logic [1:0] c_P2_SET = 2'd2;
  localparam logic [1:0] c_P2_SMP = 2'd3;

  // Next {debounced bit, counter} for one bit given a new sample. The
  // counter is cleared on the sample that commits, so it never wraps.
  function automatic logic [c_DW:0] f_deb(input logic s, input logic d,
                                          input logic [c_DW-1:0] c);
    if (s == d)
      f_deb = {d, {c_DW{1'b0}}};
    else if (c == c_DEB_LAST)
      f_deb = {s, {c_DW{1'b0}}};
    else
      f_deb = {d, c + 1'b1};
  endfunction

  // --------------------------------------------------------------------------
  // Input synchronisers (idle high)
  // --------------------------------------------------------------------------
  logic [7:0] r_jjoy_s1, r_jjoy_s2;
  logic [5:0] r_js_s1,   r_js_s2;
  logic [1:0] r_coin_s1, r_coin_s2;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_jjoy_s1 <= '1;
      r_jjoy_s2 <= '1;
      r_js_s1   <= '1;
      r_js_s2   <= '1;
      r_coin_s1 <= '1;
      r_coin_s2 <= '1;
    end else begin
      r_jjoy_s1 <= bus.JJOY;
      r_jjoy_s2 <= r_jjoy_s1;
      r_js_s1   <= bus.JOYSTICK;
      r_js_s2   <= r_js_s1;
      r_coin_s1 <= bus.JCOIN;
      r_coin_s2 <= r_coin_s1;
    end
  end

  // --------------------------------------------------------------------------
  // Scan sequencer. SETTLE clocks in *_SET cover the two synchroniser stages
  // plus external bus settling; *_SMP is a one-clock sample strobe.
  // --------------------------------------------------------------------------
  logic [1:0]      r_state;
  logic [c_SW-1:0] r_settle_cnt;
  logic            r_jselect;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state      <= c_P1_SET;
      r_settle_cnt <= '0;
      r_jselect    <= 1'b0;
    end else begin
      case (r_state)
        c_P1_SET: begin
          if (r_settle_cnt == c_SET_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= c_P1_SMP;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_P1_SMP: begin
          r_state   <= c_P2_SET;
          r_jselect <= 1'b1;
        end
        c_P2_SET: begin
          if (r_settle_cnt == c_SET_LAST) begin
            r_settle_cnt <= '0;
            r_state      <= c_P2_SMP;
          end else begin
            r_settle_cnt <= r_settle_cnt + 1'b1;
          end
        end
        c_P2_SMP: begin
          r_state   <= c_P1_SET;
          r_jselect <= 1'b0;
        end
        default: r_state <= c_P1_SET;
      endcase
    end
  end

  logic w_strobe_p1, w_strobe_p2;
  assign w_strobe_p1 = (r_state == c_P1_SMP);
  assign w_strobe_p2 = (r_state == c_P2_SMP);

  // --------------------------------------------------------------------------
  // Per-player debounce, advanced only on that player's strobe
  // --------------------------------------------------------------------------
  logic [7:0]      r_deb_p1, r_deb_p2;
  logic [c_DW-1:0] r_cnt_p1 [8];
  logic [c_DW-1:0] r_cnt_p2 [8];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_deb_p1 <= '1;
      r_deb_p2 <= '1;
      for (int i = 0; i < 8; i++) begin
        r_cnt_p1[i] <= '0;
        r_cnt_p2[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (w_strobe_p1)
          {r_deb_p1[i], r_cnt_p1[i]} <= f_deb(r_jjoy_s2[i], r_deb_p1[i], r_cnt_p1[i]);
        if (w_strobe_p2)
          {r_deb_p2[i], r_cnt_p2[i]} <= f_deb(r_jjoy_s2[i], r_deb_p2[i], r_cnt_p2[i]);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Coins: debounced every clock; a committed 1->0 starts a fixed-width pulse.
  // --------------------------------------------------------------------------
  logic [1:0]      r_coin_deb;
  logic [c_DW-1:0] r_coin_cnt [2];
  logic [1:0]      w_coin_deb_nxt;
  logic [c_DW-1:0] w_coin_cnt_nxt [2];
  logic [1:0]      r_coin_out;
  logic [c_CW-1:0] r_str_cnt [2];

  always_comb begin
    w_coin_deb_nxt = r_coin_deb;
    for (int i = 0; i < 2; i++) begin
      w_coin_cnt_nxt[i] = r_coin_cnt[i];
      {w_coin_deb_nxt[i], w_coin_cnt_nxt[i]} = f_deb(r_coin_s2[i], r_coin_deb[i], r_coin_cnt[i]);
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_coin_deb <= '1;
      r_coin_out <= '1;
      for (int i = 0; i < 2; i++) begin
        r_coin_cnt[i] <= '0;
        r_str_cnt[i]  <= '0;
      end
    end else begin
      r_coin_deb <= w_coin_deb_nxt;
      for (int i = 0; i < 2; i++) begin
        r_coin_cnt[i] <= w_coin_cnt_nxt[i];
        // While a pulse is running, new debounced edges are ignored; since
        // only a 1->0 commit starts a pulse, a held press yields one pulse.
        if (!r_coin_out[i]) begin
          if (r_str_cnt[i] == c_COIN_LAST) begin
            r_coin_out[i] <= 1'b1;
            r_str_cnt[i]  <= '0;
          end else begin
            r_str_cnt[i]  <= r_str_cnt[i] + 1'b1;
          end
        end else if (r_coin_deb[i] && !w_coin_deb_nxt[i]) begin
          r_coin_out[i] <= 1'b0;
          r_str_cnt[i]  <= '0;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output stage: merge on-board joystick into P1, optional SOCD cleaning
  // --------------------------------------------------------------------------
  logic [7:0] w_joy1_nxt, w_joy2_nxt;
  logic [7:0] r_joy1, r_joy2;

  always_comb begin
    w_joy1_nxt = r_deb_p1 & {2'b11, r_js_s2};
    w_joy2_nxt = r_deb_p2;
`ifdef JAMMA_SOCD_EN
    // Opposing directions held together cancel to neutral.
    if (w_joy1_nxt[1:0] == 2'b00) w_joy1_nxt[1:0] = 2'b11;
    if (w_joy1_nxt[3:2] == 2'b00) w_joy1_nxt[3:2] = 2'b11;
    if (w_joy2_nxt[1:0] == 2'b00) w_joy2_nxt[1:0] = 2'b11;
    if (w_joy2_nxt[3:2] == 2'b00) w_joy2_nxt[3:2] = 2'b11;
`else
    // Opposing directions pass through unmodified.
`endif
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_joy1 <= '1;
      r_joy2 <= '1;
    end else begin
      r_joy1 <= w_joy1_nxt;
      r_joy2 <= w_joy2_nxt;
    end
  end

  assign bus.JSELECT = r_jselect;
  assign bus.JOY1    = r_joy1;
  assign bus.JOY2    = r_joy2;
  assign bus.COIN    = r_coin_out;

endmodule
`default_nettype wire

// File: tb/tb_jamma_input_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jamma_input_ctrl
//  Description : Self-checking bench for jamma_input_ctrl. A behavioural
//                reference model (scan timing from clock arithmetic, delay
//                queues for synchronisers, per-bit counters, coin stretch
//                countdown) is compared every clock; table vectors and
//                hand-written sequences check the corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jamma_input_ctrl;

  localparam int SETTLE   = 4;
  localparam int DEB      = 3;
  localparam int COIN_MIN = 8192;
  localparam int PERIOD   = SETTLE + 1;

  logic CLK = 1'b0;
  logic RESET_N;
  logic [7:0] p1_pins, p2_pins;

  jamma_input_ctrl_if bus ();

  jamma_input_ctrl #(
    .SETTLE    (SETTLE),
    .DEB_COUNT (DEB),
    .COIN_MIN  (COIN_MIN)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .bus     (bus)
  );

  initial forever #5 CLK = ~CLK;

  // Board model: the selected player's harness drives the shared bus.
  always_comb bus.JJOY = bus.JSELECT ? p2_pins : p1_pins;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: actual %0h, required %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model
  // --------------------------------------------------------------------------
  int         k;
  logic       m_sel;
  logic [7:0] q_j[$];
  logic [5:0] q_s[$];
  logic [1:0] q_c[$];
  logic [7:0] deb1, deb2;
  int         cnt1[8], cnt2[8];
  logic [1:0] cdeb;
  int         ccnt[2];
  int         rem[2];
  logic [7:0] e_joy1, e_joy2;
  logic [1:0] e_coin;

  function automatic logic [7:0] socd(input logic [7:0] v);
    logic [7:0] r;
    r = v;
`ifdef JAMMA_SOCD_EN
    if (!r[0] && !r[1]) begin r[0] = 1'b1; r[1] = 1'b1; end
    if (!r[2] && !r[3]) begin r[2] = 1'b1; r[3] = 1'b1; end
`endif
    return r;
  endfunction

  function automatic void deb_step(input logic s, input logic d_in, input int c_in,
                                   output logic d_out, output int c_out);
    d_out = d_in;
    if (s == d_in) c_out = 0;
    else begin
      c_out = c_in + 1;
      if (c_out >= DEB) begin d_out = s; c_out = 0; end
    end
  endfunction

  task automatic model_reset();
    k = 0; m_sel = 1'b0;
    q_j.delete(); q_s.delete(); q_c.delete();
    repeat (2) begin q_j.push_back(8'hFF); q_s.push_back(6'h3F); q_c.push_back(2'b11); end
    deb1 = 8'hFF; deb2 = 8'hFF; cdeb = 2'b11;
    for (int i = 0; i < 8; i++) begin cnt1[i] = 0; cnt2[i] = 0; end
    for (int i = 0; i < 2; i++) begin ccnt[i] = 0; rem[i] = 0; end
    e_joy1 = 8'hFF; e_joy2 = 8'hFF; e_coin = 2'b11;
  endtask

  task automatic model_step();
    logic [7:0] bus_v, j2;
    logic [5:0] s2;
    logic [1:0] c2;
    logic       old, nd;
    int         nc;
    bus_v = m_sel ? p2_pins : p1_pins;
    j2 = q_j.pop_front(); q_j.push_back(bus_v);
    s2 = q_s.pop_front(); q_s.push_back(bus.JOYSTICK);
    c2 = q_c.pop_front(); q_c.push_back(bus.JCOIN);
    k++;
    e_joy1 = socd(deb1 & {2'b11, s2});
    e_joy2 = socd(deb2);
    if (k % PERIOD == 0) begin
      for (int i = 0; i < 8; i++) begin
        if ((k / PERIOD) % 2 == 1) begin
          deb_step(j2[i], deb1[i], cnt1[i], nd, nc); deb1[i] = nd; cnt1[i] = nc;
        end else begin
          deb_step(j2[i], deb2[i], cnt2[i], nd, nc); deb2[i] = nd; cnt2[i] = nc;
        end
      end
      m_sel = ((k / PERIOD) % 2 == 1);
    end
    for (int i = 0; i < 2; i++) begin
      old = cdeb[i];
      deb_step(c2[i], cdeb[i], ccnt[i], nd, nc); cdeb[i] = nd; ccnt[i] = nc;
      if (rem[i] > 0) rem[i]--;
      else if (old && !cdeb[i]) rem[i] = COIN_MIN;
      e_coin[i] = (rem[i] > 0) ? 1'b0 : 1'b1;
    end
  endtask

  initial begin
    forever begin
      @(posedge CLK); #1;
      if (!RESET_N) model_reset();
      else model_step();
      check("model_cycle", {13'd0, bus.JSELECT, bus.JOY1, bus.JOY2, bus.COIN},
                           {13'd0, m_sel, e_joy1, e_joy2, e_coin});
    end
  end

  // --------------------------------------------------------------------------
  // Cycle counter and coin pulse monitor
  // --------------------------------------------------------------------------
  int cyc = 0;
  int run[2], pulses[2], last_len[2], start_cyc[2];

  initial begin
    for (int i = 0; i < 2; i++) begin run[i] = 0; pulses[i] = 0; last_len[i] = 0; start_cyc[i] = 0; end
    forever begin
      @(posedge CLK); #2;
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (bus.COIN[i] == 1'b0) begin
          if (run[i] == 0) start_cyc[i] = cyc;
          run[i]++;
        end else if (run[i] > 0) begin
          pulses[i]++; last_len[i] = run[i]; run[i] = 0;
        end
      end
    end
  end

  task automatic clear_coin_stats();
    for (int i = 0; i < 2; i++) begin pulses[i] = 0; last_len[i] = 0; end
  endtask

  task automatic wait_sel(input logic v, input string nm);
    int n;
    n = 0;
    while (bus.JSELECT !== v && n < 40) begin @(negedge CLK); n++; end
    if (bus.JSELECT !== v) begin
      n_checks++; n_fail++;
      $display("FAIL %s: JSELECT timeout, actual %b, required %b", nm, bus.JSELECT, v);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // Watchdog
  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "watchdog");
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  typedef struct {
    logic [7:0] p1;
    logic [7:0] p2;
    logic [5:0] js;
    logic [7:0] e1;
    logic [7:0] e2;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0, t1, press;

    vecs[0] = '{8'hFE, 8'hFF, 6'h3F, 8'hFE, 8'hFF};
    vecs[1] = '{8'hFF, 8'hEF, 6'h3F, 8'hFF, 8'hEF};
    vecs[2] = '{8'hFF, 8'hFF, 6'h3B, 8'hFB, 8'hFF};
    vecs[3] = '{8'h7F, 8'h3F, 6'h3E, 8'h7E, 8'h3F};
    vecs[6] = '{8'hAA, 8'h55, 6'h3F, 8'hAA, 8'h55};
`ifdef JAMMA_SOCD_EN
    vecs[4] = '{8'hF3, 8'hF3, 6'h3F, 8'hFF, 8'hFF};
    vecs[5] = '{8'hFF, 8'hFF, 6'h33, 8'hFF, 8'hFF};
    vecs[7] = '{8'h00, 8'h00, 6'h3F, 8'h0F, 8'h0F};
`else
    vecs[4] = '{8'hF3, 8'hF3, 6'h3F, 8'hF3, 8'hF3};
    vecs[5] = '{8'hFF, 8'hFF, 6'h33, 8'hF3, 8'hFF};
    vecs[7] = '{8'h00, 8'h00, 6'h3F, 8'h00, 8'h00};
`endif

    RESET_N = 1'b0;
    p1_pins = 8'hFF; p2_pins = 8'hFF;
    bus.JOYSTICK = 6'h3F; bus.JCOIN = 2'b11;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("reset_outputs", {13'd0, bus.JSELECT, bus.JOY1, bus.JOY2, bus.COIN},
                           {13'd0, 1'b0, 8'hFF, 8'hFF, 2'b11});
    RESET_N = 1'b1;

    // Scan period: JSELECT toggles every SETTLE+1 clocks.
    wait_sel(1'b1, "sel_rise"); t0 = cyc;
    wait_sel(1'b0, "sel_fall"); t1 = cyc;
    check("sel_period_hi", t1 - t0, PERIOD);
    wait_sel(1'b1, "sel_rise2"); t0 = cyc;
    check("sel_period_lo", t0 - t1, PERIOD);
    check("idle_outputs", {bus.JOY1, bus.JOY2, 6'd0, bus.COIN}, {8'hFF, 8'hFF, 6'd0, 2'b11});

    // Table vectors
    for (int v = 0; v < 8; v++) begin
      p1_pins = vecs[v].p1; p2_pins = vecs[v].p2; bus.JOYSTICK = vecs[v].js;
      idle(50);
      check($sformatf("vec%0d_joy1", v), bus.JOY1, vecs[v].e1);
      check($sformatf("vec%0d_joy2", v), bus.JOY2, vecs[v].e2);
    end
    p1_pins = 8'hFF; p2_pins = 8'hFF; bus.JOYSTICK = 6'h3F;
    idle(50);

    // Glitch on P2 fire1 for two strobes only: no change.
    wait_sel(1'b0, "g0"); wait_sel(1'b1, "g1");
    p2_pins = 8'hEF;
    wait_sel(1'b0, "g2"); wait_sel(1'b1, "g3"); wait_sel(1'b0, "g4");
    p2_pins = 8'hFF;
    idle(40);
    check("glitch_2_strobes", bus.JOY2, 8'hFF);

    // Held for three strobes: commits, visible one clock after 3rd strobe.
    wait_sel(1'b1, "h1");
    p2_pins = 8'hEF;
    wait_sel(1'b0, "h2"); wait_sel(1'b1, "h3"); wait_sel(1'b0, "h4");
    wait_sel(1'b1, "h5"); wait_sel(1'b0, "h6");
    check("hold3_before_out", bus.JOY2, 8'hFF);
    @(negedge CLK);
    check("hold3_joy2", bus.JOY2, 8'hEF);
    p2_pins = 8'hFF;
    idle(50);

    // Coin 0: 100-clock press, second press inside the window.
    clear_coin_stats();
    press = cyc;
    bus.JCOIN = 2'b10; idle(100); bus.JCOIN = 2'b11;
    idle(50);
    check("coin0_low_mid", bus.COIN, 2'b10);
    idle(150);
    bus.JCOIN = 2'b10; idle(100); bus.JCOIN = 2'b11;
    idle(COIN_MIN);
    check("coin0_start", start_cyc[0], press + 2 + DEB);
    check("coin0_pulses", pulses[0], 1);
    check("coin0_width", last_len[0], COIN_MIN);
    check("coin1_quiet", pulses[1], 0);

    // Both coins together, held longer than COIN_MIN.
    clear_coin_stats();
    press = cyc;
    bus.JCOIN = 2'b00; idle(COIN_MIN + 800); bus.JCOIN = 2'b11;
    idle(200);
    check("both_pulses0", pulses[0], 1);
    check("both_pulses1", pulses[1], 1);
    check("both_width0", last_len[0], COIN_MIN);
    check("both_width1", last_len[1], COIN_MIN);
    check("both_start0", start_cyc[0], press + 2 + DEB);
    check("both_start1", start_cyc[1], press + 2 + DEB);

    // Async reset in the middle of P2_SET with live outputs.
    p1_pins = 8'hFE;
    idle(50);
    bus.JCOIN = 2'b10; idle(20); bus.JCOIN = 2'b11;
    wait_sel(1'b0, "r0"); wait_sel(1'b1, "r1");
    @(negedge CLK);
    check("pre_reset", {13'd0, bus.JSELECT, bus.JOY1, bus.JOY2, bus.COIN},
                       {13'd0, 1'b1, 8'hFE, 8'hFF, 2'b10});
    #2 RESET_N = 1'b0;
    #1;
    check("async_reset", {13'd0, bus.JSELECT, bus.JOY1, bus.JOY2, bus.COIN},
                         {13'd0, 1'b0, 8'hFF, 8'hFF, 2'b11});
    p1_pins = 8'hFF;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b1;

    // Randomised traffic checked every clock by the model.
    for (int s = 0; s < 60; s++) begin
      p1_pins = 8'($urandom | $urandom);
      p2_pins = 8'($urandom | $urandom);
      bus.JOYSTICK = 6'($urandom | $urandom);
      bus.JCOIN = ($urandom_range(0, 7) == 0) ? 2'($urandom) : 2'b11;
      idle($urandom_range(1, 25));
    end
    p1_pins = 8'hFF; p2_pins = 8'hFF; bus.JOYSTICK = 6'h3F; bus.JCOIN = 2'b11;
    idle(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
